stage_decode: RTL and testbench
===============================

// Module: stage_decode
// PURPOSE
//  Second stage of the 3-stage RV32I pipeline, directly downstream of stage_fetch.
//  - Registers instrF/pcF into the IF/ID register.
//  - Decodes immediates, reads the regfile and forwards from writeback.
//  - Resolves branches/jumps and drives pc_selD, jump_result, branch_result back to fetch.
//  - Runs a small RUN/KILL/STALL FSM that inserts a bubble after every redirect.
// PARAMETERS
//  XLEN      32            datapath width
//  RESET_PC  32'h4000_0000 pcD value on reset; matches fetch reset PC
//  NOP       32'h0000_0013 addi x0,x0,0; bubble encoding
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous reset, active-high
//  instrF         in   XLEN  instruction fetched at pcF, valid in the same cycle
//  pcF            in   XLEN  fetch PC
//  stall_in       in   1     downstream stall, e.g. dmem busy
//  rs1_addr       out  5     regfile read address, = instrD[19:15]
//  rs2_addr       out  5     regfile read address, = instrD[24:20]
//  rs1_data       in   XLEN  regfile read data, combinational
//  rs2_data       in   XLEN  regfile read data, combinational
//  wb_we          in   1     writeback write enable
//  wb_rd          in   5     writeback destination register
//  wb_data        in   XLEN  writeback data
//  stallF         out  1     hold fetch PC
//  pc_selD        out  2     00 = pc+4, 01 = jump, 10 = branch taken; 11 is never driven
//  jump_result    out  XLEN  JAL/JALR target
//  branch_result  out  XLEN  branch target pcD+immB
//  instrD         out  XLEN  IF/ID instruction, or NOP when killed
//  pcD            out  XLEN  IF/ID PC
//  validD         out  1     instrD is a real, non-killed instruction
//  immD           out  XLEN  sign-extended immediate (I/S/B/U/J by opcode, else 0)
//  rs1_fwd        out  XLEN  forwarded rs1 operand
//  rs2_fwd        out  XLEN  forwarded rs2 operand
//  dec_count      out  32    number of valid instructions that left decode
// BEHAVIOUR
//  Reset: state=RUN, instrD=NOP, pcD=RESET_PC, validD=0, dec_count=0.
//  Reset is evaluated every cycle, so a reset mid-stall or mid-kill returns to these values on the next edge.
//  Forwarding:
//   - rsN_fwd = wb_data when wb_we && wb_rd==rsN_addr && wb_rd!=0; otherwise rsN_data.
//   - rsN_fwd = 0 whenever rsN_addr==0.
//  Immediates follow RV32I formats. B and J immediates have bit0=0.
//  Targets (32-bit arithmetic, wrap modulo 2^32, no overflow flag):
//   - JAL:           jump_result = pcD + immJ.
//   - JALR:          jump_result = (rs1_fwd + immI) & ~1.
//   - Other opcodes: jump_result = 0.
//   - branch_result = pcD + immB, always computed.
//  Taken condition (funct3), on forwarded operands:
//   - BEQ / BNE: equal / not equal.
//   - BLT / BGE: signed compare.
//   - BLTU / BGEU: unsigned compare.
//   - Undefined branch funct3 is not taken.
//  redirect = validD && !stall_in && (JAL || JALR || branch taken).
//  pc_selD:
//   - 01 for JAL/JALR, 10 for a taken branch, only while redirect=1.
//   - 00 in all other cases, including state KILL, validD=0, and stall_in=1.
//  stallF = stall_in. Combinational, 0-cycle latency.
//  FSM, registered and updated each posedge:
//   - RUN:
//     - stall_in=1: go to STALL. Hold instrD/pcD/validD.
//     - else redirect=1: go to KILL. Load instrD=NOP, validD=0, pcD=pcF. This squashes the wrong-path instrF.
//     - else: stay in RUN. Load instrD=instrF, pcD=pcF, validD=1.
//   - KILL: lasts one cycle and issues no redirect.
//     - stall_in=1: go to STALL.
//     - else: go to RUN and load instrF, which is the redirect target, with validD=1.
//   - STALL: hold instrD/pcD/validD.
//     - Exit to RUN when stall_in=0.
//     - The held instruction re-evaluates redirect on the exit cycle.
//  Stall vs redirect in the same cycle: stall wins. The redirect is deferred, not lost, because the instruction is held.
//  Stall during KILL: the bubble is held. On release, instrF is loaded normally.
//  dec_count:
//   - +1 on each edge where validD=1, stall_in=0 and state!=STALL.
//   - Wraps from 32'hFFFF_FFFF to 0.
// TESTING
//  1. Reset for 2 cycles, then release.
//     -> instrD=0x00000013, validD=0, pcD=0x40000000, pc_selD=00, dec_count=0.
//  2. Feed addi at pcF=0x40000000 then 0x40000004.
//     -> pcD follows one cycle later, validD=1, pc_selD=00, dec_count increments by 1 per instruction.
//  3. jal x1,+16 at pcD=0x40000008.
//     -> pc_selD=01, jump_result=0x40000018.
//     -> next cycle instrD=NOP, validD=0.
//     -> following cycle instrD is the target instruction.
//  4. beq with rs1=rs2=5 via wb forwarding (wb_we=1, wb_rd=rs1, wb_data=5, regfile rs1_data=0), imm=-8, pcD=0x40000020.
//     -> pc_selD=10, branch_result=0x40000018.
//     -> Repeat with bne: pc_selD=00 and no bubble.
//  5. stall_in=1 for 3 cycles while a taken blt is in decode.
//     -> stallF=1, pc_selD=00, instrD held, dec_count frozen.
//     -> On release: pc_selD=10 for one cycle, then a bubble.
//  6. jalr with rs1=0x40000103, imm=0, then assert rst during KILL.
//     -> jump_result=0x40000102.
//     -> Next cycle: reset values from scenario 1.

Source files
------------

// File: rtl/stage_decode.sv
// Decode stage of the 3-stage RV32I pipeline: IF/ID register, immediate decode, operand
// forwarding from writeback, branch/jump resolution and a one-bubble squash after redirects.
module stage_decode #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0000,
  parameter logic [XLEN-1:0] NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instrF,
  input  logic [XLEN-1:0] pcF,
  input  logic            stall_in,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stallF,
  output logic [1:0]      pc_selD,
  output logic [XLEN-1:0] jump_result,
  output logic [XLEN-1:0] branch_result,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic            validD,
  output logic [XLEN-1:0] immD,
  output logic [XLEN-1:0] rs1_fwd,
  output logic [XLEN-1:0] rs2_fwd,
  output logic [31:0]     dec_count
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [1:0] {StRun, StKill, StStall} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [31:0]     count_q, count_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] jalr_sum;
  logic            is_jal, is_jalr, is_branch;
  logic            taken, redirect;

  assign opcode    = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign is_jal    = (opcode == OpJal);
  assign is_jalr   = (opcode == OpJalr);
  assign is_branch = (opcode == OpBranch);

  assign imm_i = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{(XLEN-12){instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{(XLEN-20){instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  always_comb begin
    immD = '0;
    case (opcode)
      OpLoad, OpOpImm, OpJalr: immD = imm_i;
      OpStore:                 immD = imm_s;
      OpBranch:                immD = imm_b;
      OpLui, OpAuipc:          immD = imm_u;
      OpJal:                   immD = imm_j;
      default:                 immD = '0;
    endcase
  end

  assign rs1_addr = instr_q[19:15];
  assign rs2_addr = instr_q[24:20];

  // x0 reads as zero even if writeback or the regfile disagree.
  always_comb begin
    rs1_fwd = rs1_data;
    if (wb_we && (wb_rd == rs1_addr) && (wb_rd != 5'd0)) rs1_fwd = wb_data;
    if (rs1_addr == 5'd0) rs1_fwd = '0;
    rs2_fwd = rs2_data;
    if (wb_we && (wb_rd == rs2_addr) && (wb_rd != 5'd0)) rs2_fwd = wb_data;
    if (rs2_addr == 5'd0) rs2_fwd = '0;
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (rs1_fwd == rs2_fwd);
      3'b001:  taken = (rs1_fwd != rs2_fwd);
      3'b100:  taken = ($signed(rs1_fwd) < $signed(rs2_fwd));
      3'b101:  taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      3'b110:  taken = (rs1_fwd < rs2_fwd);
      3'b111:  taken = (rs1_fwd >= rs2_fwd);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum      = rs1_fwd + imm_i;
  assign branch_result = pc_q + imm_b;

  always_comb begin
    jump_result = '0;
    if (is_jal)       jump_result = pc_q + imm_j;
    else if (is_jalr) jump_result = {jalr_sum[XLEN-1:1], 1'b0};
  end

  // A bubble is never valid, so the kill state cannot redirect again.
  assign redirect = valid_q && !stall_in && (is_jal || is_jalr || (is_branch && taken));

  always_comb begin
    pc_selD = 2'b00;
    if (redirect) pc_selD = (is_jal || is_jalr) ? 2'b01 : 2'b10;
  end

  assign stallF    = stall_in;
  assign instrD    = instr_q;
  assign pcD       = pc_q;
  assign validD    = valid_q;
  assign dec_count = count_q;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    count_d = count_q;
    if (valid_q && !stall_in && (state_q != StStall)) count_d = count_q + 32'd1;
    case (state_q)
      StRun, StStall: begin
        if (stall_in) begin
          state_d = StStall;
        end else if (redirect) begin
          state_d = StKill;
          instr_d = NOP;
          pc_d    = pcF;
          valid_d = 1'b0;
        end else begin
          state_d = StRun;
          instr_d = instrF;
          pc_d    = pcF;
          valid_d = 1'b1;
        end
      end
      StKill: begin
        if (stall_in) begin
          state_d = StStall;
        end else begin
          state_d = StRun;
          instr_d = instrF;
          pc_d    = pcF;
          valid_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      instr_q <= NOP;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_stage_decode.sv
// Bench for stage_decode: directed pipeline scenarios followed by random traffic, all outputs
// compared every cycle against an instruction-level reference model.
module tb_stage_decode;

  localparam logic [31:0] ResetPc = 32'h4000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] instrF, pcF;
  logic        stall_in;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stallF;
  logic [1:0]  pc_selD;
  logic [31:0] jump_result, branch_result, instrD, pcD;
  logic        validD;
  logic [31:0] immD, rs1_fwd, rs2_fwd, dec_count;

  stage_decode dut (
    .clk          (clk),
    .rst          (rst),
    .instrF       (instrF),
    .pcF          (pcF),
    .stall_in     (stall_in),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stallF       (stallF),
    .pc_selD      (pc_selD),
    .jump_result  (jump_result),
    .branch_result(branch_result),
    .instrD       (instrD),
    .pcD          (pcD),
    .validD       (validD),
    .immD         (immD),
    .rs1_fwd      (rs1_fwd),
    .rs2_fwd      (rs2_fwd),
    .dec_count    (dec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: the instruction sitting in decode plus a mode word.
  logic [31:0] m_instr, m_pc, m_count;
  logic        m_valid;
  int          m_mode;  // 0 normal, 1 squashing, 2 stalled

  logic [31:0] e_imm, e_jump, e_branch, e_a, e_b;
  logic [1:0]  e_sel;
  logic        e_redir;

  function automatic logic [31:0] imm_i(input logic [31:0] x);
    logic signed [11:0] t;
    int v;
    t = x[31:20];
    v = t;
    return v;
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] x);
    logic signed [11:0] t;
    int v;
    t = {x[31:25], x[11:7]};
    v = t;
    return v;
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] x);
    logic signed [12:0] t;
    int v;
    t = {x[31], x[7], x[30:25], x[11:8], 1'b0};
    v = t;
    return v;
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] x);
    logic signed [20:0] t;
    int v;
    t = {x[31], x[19:12], x[20], x[30:21], 1'b0};
    v = t;
    return v;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_rd == a) return wb_data;
    return d;
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs1, input int rs2, input int f3);
    logic [12:0] t;
    t = imm[12:0];
    return {t[12], t[10:5], rs2[4:0], rs1[4:0], f3[2:0], t[4:1], t[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] t;
    t = imm[20:0];
    return {t[20], t[10:1], t[11], t[19:12], rd[4:0], 7'h6F};
  endfunction

  task automatic model_outputs();
    logic [6:0] op;
    logic       tk, jmp;
    op    = m_instr[6:0];
    e_a   = fwd(m_instr[19:15], rs1_data);
    e_b   = fwd(m_instr[24:20], rs2_data);
    case (op)
      7'h13, 7'h03, 7'h67: e_imm = imm_i(m_instr);
      7'h23:               e_imm = imm_s(m_instr);
      7'h63:               e_imm = imm_b(m_instr);
      7'h37, 7'h17:        e_imm = {m_instr[31:12], 12'h000};
      7'h6F:               e_imm = imm_j(m_instr);
      default:             e_imm = 32'd0;
    endcase
    case (m_instr[14:12])
      3'd0:    tk = (e_a == e_b);
      3'd1:    tk = (e_a != e_b);
      3'd4:    tk = ($signed(e_a) < $signed(e_b));
      3'd5:    tk = !($signed(e_a) < $signed(e_b));
      3'd6:    tk = (e_a < e_b);
      3'd7:    tk = !(e_a < e_b);
      default: tk = 1'b0;
    endcase
    jmp      = (op == 7'h6F) || (op == 7'h67);
    e_branch = m_pc + imm_b(m_instr);
    if (op == 7'h6F)      e_jump = m_pc + imm_j(m_instr);
    else if (op == 7'h67) e_jump = (e_a + imm_i(m_instr)) & 32'hFFFF_FFFE;
    else                  e_jump = 32'd0;
    e_redir = m_valid && !stall_in && (jmp || (op == 7'h63 && tk));
    e_sel   = !e_redir ? 2'd0 : (jmp ? 2'd1 : 2'd2);
  endtask

  task automatic model_step();
    model_outputs();
    if (rst) begin
      m_mode = 0; m_instr = Nop; m_pc = ResetPc; m_valid = 1'b0; m_count = 32'd0;
    end else if (stall_in) begin
      m_mode = 2;
    end else begin
      if (m_valid && m_mode != 2) m_count = m_count + 32'd1;
      m_pc = pcF;
      if (e_redir) begin
        m_mode = 1; m_instr = Nop; m_valid = 1'b0;
      end else begin
        m_mode = 0; m_instr = instrF; m_valid = 1'b1;
      end
    end
  endtask

  // Compare every output on the falling edge, with inputs settled since the rising edge.
  task automatic sample();
    @(negedge clk);
    model_outputs();
    check("instrD", instrD, m_instr);
    check("pcD", pcD, m_pc);
    check("validD", {31'd0, validD}, {31'd0, m_valid});
    check("dec_count", dec_count, m_count);
    check("stallF", {31'd0, stallF}, {31'd0, stall_in});
    check("pc_selD", {30'd0, pc_selD}, {30'd0, e_sel});
    check("immD", immD, e_imm);
    check("jump_result", jump_result, e_jump);
    check("branch_result", branch_result, e_branch);
    check("rs1_addr", {27'd0, rs1_addr}, {27'd0, m_instr[19:15]});
    check("rs2_addr", {27'd0, rs2_addr}, {27'd0, m_instr[24:20]});
    check("rs1_fwd", rs1_fwd, e_a);
    check("rs2_fwd", rs2_fwd, e_b);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_instrD"}, instrD, 32'h0000_0013);
    check({tag, "_validD"}, {31'd0, validD}, 32'd0);
    check({tag, "_pcD"}, pcD, 32'h4000_0000);
    check({tag, "_pc_selD"}, {30'd0, pc_selD}, 32'd0);
    check({tag, "_dec_count"}, dec_count, 32'd0);
  endtask

  logic [31:0] addi1, addi2, tgt, frozen, blt_i, r;
  logic [6:0]  ops [10] = '{7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h63, 7'h33};

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst = 1'b1; instrF = Nop; pcF = ResetPc; stall_in = 1'b0;
    rs1_data = '0; rs2_data = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    m_mode = 0; m_instr = Nop; m_pc = ResetPc; m_valid = 1'b0; m_count = '0;
    advance();
    advance();
    rst = 1'b0;

    // Reset state
    sample();
    check_reset_values("rst");

    // Straight-line addis
    addi1 = enc_i(1, 0, 0, 1, 7'h13);
    addi2 = enc_i(2, 0, 0, 2, 7'h13);
    instrF = addi1; pcF = 32'h4000_0000;
    advance();
    instrF = addi2; pcF = 32'h4000_0004;
    sample();
    check("seq_pcD0", pcD, 32'h4000_0000);
    check("seq_valid0", {31'd0, validD}, 32'd1);
    advance();
    instrF = enc_j(16, 1); pcF = 32'h4000_0008;
    sample();
    check("seq_pcD1", pcD, 32'h4000_0004);
    check("seq_count1", dec_count, 32'd1);
    advance();

    // JAL: redirect, bubble, then target
    instrF = addi1; pcF = 32'h4000_000C;
    sample();
    check("jal_sel", {30'd0, pc_selD}, 32'd1);
    check("jal_target", jump_result, 32'h4000_0018);
    advance();
    tgt = enc_i(5, 0, 0, 5, 7'h13);
    instrF = tgt; pcF = 32'h4000_0018;
    sample();
    check("jal_bubble_instr", instrD, Nop);
    check("jal_bubble_valid", {31'd0, validD}, 32'd0);
    advance();
    instrF = enc_b(-8, 2, 3, 0); pcF = 32'h4000_0020;
    sample();
    check("jal_tgt_instr", instrD, tgt);
    advance();

    // BEQ taken through writeback forwarding on rs1
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'd5; rs1_data = 32'd0; rs2_data = 32'd5;
    instrF = addi1; pcF = 32'h4000_0024;
    sample();
    check("beq_sel", {30'd0, pc_selD}, 32'd2);
    check("beq_target", branch_result, 32'h4000_0018);
    advance();
    instrF = enc_b(-8, 2, 3, 1); pcF = 32'h4000_0018;
    sample();
    advance();
    instrF = addi2; pcF = 32'h4000_001C;
    sample();
    check("bne_sel", {30'd0, pc_selD}, 32'd0);
    advance();
    sample();
    check("bne_no_bubble", {31'd0, validD}, 32'd1);

    // BLT taken but held under a 3-cycle stall
    wb_we = 1'b0; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1;
    blt_i = enc_b(64, 2, 3, 4);
    instrF = blt_i; pcF = 32'h4000_0040;
    advance();
    stall_in = 1'b1; instrF = addi1; pcF = 32'h4000_0044;
    frozen = m_count;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("stall_stallF", {31'd0, stallF}, 32'd1);
      check("stall_sel", {30'd0, pc_selD}, 32'd0);
      check("stall_instr", instrD, blt_i);
      check("stall_count", dec_count, frozen);
      advance();
    end
    stall_in = 1'b0;
    sample();
    check("stall_release_sel", {30'd0, pc_selD}, 32'd2);
    advance();
    sample();
    check("stall_release_bubble", {31'd0, validD}, 32'd0);
    instrF = enc_i(0, 4, 0, 1, 7'h67); pcF = 32'h4000_0080;
    advance();

    // JALR target, then reset during the bubble
    rs1_data = 32'h4000_0103; instrF = addi1; pcF = 32'h4000_0084;
    sample();
    check("jalr_target", jump_result, 32'h4000_0102);
    check("jalr_sel", {30'd0, pc_selD}, 32'd1);
    advance();
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    sample();
    check_reset_values("kill_rst");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      advance();
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom());
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      instrF   = r;
      pcF      = $urandom() & 32'hFFFF_FFFC;
      rs1_data = pick_data();
      rs2_data = pick_data();
      wb_we    = 1'($urandom_range(0, 1));
      wb_rd    = 5'($urandom_range(0, 3));
      wb_data  = pick_data();
      stall_in = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      sample();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
